// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared states, frame constants and CRC7 helpers for the SPI slave receiver
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARG       = 3'd1,
    ST_CRC       = 3'd2,
    ST_DATA_WAIT = 3'd3,
    ST_DATA      = 3'd4,
    ST_DATA_CRC  = 3'd5
  } state_t;

  localparam logic [5:0] CMD_WRITE_BLOCK = 6'd24;
  localparam logic [7:0] DATA_TOKEN      = 8'hFE;
  localparam logic [1:0] START_PATTERN   = 2'b01;
  localparam logic [5:0] ARG_BITS        = 6'd32;
  localparam logic [5:0] CRC_BITS        = 6'd8;
  localparam logic [5:0] DATA_CRC_BITS   = 6'd16;

  // x^7 + x^3 + 1, MSB-first serial update
  function automatic logic [6:0] crc7_bit(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] data);
    logic [6:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) c = crc7_bit(c, data[i]);
    return c;
  endfunction

endpackage

// File: rtl/spi_crc7.sv
// rtl/spi_crc7.sv - serial bit-in CRC7 with seeded clear and enable (built with SPI_CRC7_CHECK_EN)
`ifdef SPI_CRC7_CHECK_EN
module spi_crc7
  import spi_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       i_clear,
  input  logic [6:0] i_seed,
  input  logic       i_enable,
  input  logic       i_bit,
  output logic [6:0] o_crc
);

  logic [6:0] r_crc;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_crc <= 7'd0;
    end else if (i_clear) begin
      r_crc <= i_seed;
    end else if (i_enable) begin
      r_crc <= crc7_bit(r_crc, i_bit);
    end
  end

  assign o_crc = r_crc;

endmodule
`endif

// File: rtl/spi_slave_receiver.sv
// rtl/spi_slave_receiver.sv - SPI command frame / write-data receiver; SPI_CRC7_CHECK_EN enables CRC7 checking
module spi_slave_receiver
  import spi_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  io_InputBuffer,
  input  logic        io_BufferChanged,
  input  logic [31:0] io_DataBlockSize,
  output logic        io_CommandReadFinished,
  output logic        io_ArgumentReadFinished,
  output logic        io_ReadSuccess,
  output logic [5:0]  io_Command,
  output logic [31:0] io_CommandArgument,
  output logic [2:0]  io____state
);

  state_t      r_state;
  logic        r_changed_d;
  logic [5:0]  r_bit_cnt;
  logic [34:0] r_data_cnt;
  logic        r_cmd_done;
  logic        r_arg_done;
  logic        r_success;
  logic [5:0]  r_cmd;
  logic [31:0] r_arg;

  logic        w_event;
  logic        w_start;
  logic [5:0]  w_bit_next;
  logic [34:0] w_data_next;
  logic [34:0] w_data_total;
  logic        w_crc_ok;
  logic        w_frame_ok;

  assign w_event      = io_BufferChanged & ~r_changed_d;
  assign w_start      = (io_InputBuffer[7:6] == START_PATTERN);
  assign w_bit_next   = r_bit_cnt + 6'd1;
  assign w_data_next  = r_data_cnt + 35'd1;
  assign w_data_total = {io_DataBlockSize, 3'b000};

`ifdef SPI_CRC7_CHECK_EN
  logic [6:0] w_crc;
  logic [6:0] w_crc_seed;

  // The command byte is already complete when the start is seen, so it seeds the CRC in one step
  assign w_crc_seed = crc7_byte(7'd0, io_InputBuffer);

  spi_crc7 u_crc7 (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_event && (r_state == ST_IDLE) && w_start),
    .i_seed   (w_crc_seed),
    .i_enable (w_event && (r_state == ST_ARG)),
    .i_bit    (io_InputBuffer[0]),
    .o_crc    (w_crc)
  );

  assign w_crc_ok = (io_InputBuffer[7:1] == w_crc);
`else
  assign w_crc_ok = 1'b1;
`endif

  assign w_frame_ok = io_InputBuffer[0] & w_crc_ok;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_changed_d <= 1'b0;
      r_bit_cnt   <= 6'd0;
      r_data_cnt  <= 35'd0;
      r_cmd_done  <= 1'b0;
      r_arg_done  <= 1'b0;
      r_success   <= 1'b0;
      r_cmd       <= 6'd0;
      r_arg       <= 32'd0;
    end else begin
      r_changed_d <= io_BufferChanged;
      case (r_state)
        ST_IDLE: begin
          if (w_event && w_start) begin
            r_cmd      <= io_InputBuffer[5:0];
            r_cmd_done <= 1'b1;
            r_arg_done <= 1'b0;
            r_success  <= 1'b0;
            r_bit_cnt  <= 6'd0;
            r_state    <= ST_ARG;
          end
        end
        ST_ARG: begin
          if (w_event) begin
            r_bit_cnt <= w_bit_next;
            if (w_bit_next[2:0] == 3'd0) r_arg <= {r_arg[23:0], io_InputBuffer};
            if (w_bit_next == ARG_BITS) begin
              r_arg_done <= 1'b1;
              r_bit_cnt  <= 6'd0;
              r_state    <= ST_CRC;
            end
          end
        end
        ST_CRC: begin
          if (w_event) begin
            r_bit_cnt <= w_bit_next;
            if (w_bit_next == CRC_BITS) begin
              r_success <= w_frame_ok;
              r_bit_cnt <= 6'd0;
              r_state   <= (w_frame_ok && r_cmd == CMD_WRITE_BLOCK) ? ST_DATA_WAIT : ST_IDLE;
            end
          end
        end
        ST_DATA_WAIT: begin
          if (w_event && io_InputBuffer == DATA_TOKEN) begin
            r_data_cnt <= 35'd0;
            r_bit_cnt  <= 6'd0;
            r_state    <= (io_DataBlockSize == 32'd0) ? ST_DATA_CRC : ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_event) begin
            r_data_cnt <= w_data_next;
            if (w_data_next == w_data_total) begin
              r_bit_cnt <= 6'd0;
              r_state   <= ST_DATA_CRC;
            end
          end
        end
        ST_DATA_CRC: begin
          if (w_event) begin
            r_bit_cnt <= w_bit_next;
            if (w_bit_next == DATA_CRC_BITS) begin
              r_bit_cnt <= 6'd0;
              r_state   <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_CommandReadFinished  = r_cmd_done;
  assign io_ArgumentReadFinished = r_arg_done;
  assign io_ReadSuccess          = r_success;
  assign io_Command              = r_cmd;
  assign io_CommandArgument      = r_arg;
  assign io____state             = r_state;

endmodule

// File: tb/tb_spi_slave_receiver.sv
// tb/tb_spi_slave_receiver.sv - self-checking bench for spi_slave_receiver
module tb_spi_slave_receiver;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  tb_buf = 8'hFF;
  logic        changed = 1'b0;
  logic [31:0] size = 32'd0;
  logic        cmd_done, arg_done, success;
  logic [5:0]  cmd;
  logic [31:0] arg;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;

  spi_slave_receiver dut (
    .clock                   (clock),
    .reset                   (reset),
    .io_InputBuffer          (tb_buf),
    .io_BufferChanged        (changed),
    .io_DataBlockSize        (size),
    .io_CommandReadFinished  (cmd_done),
    .io_ArgumentReadFinished (arg_done),
    .io_ReadSuccess          (success),
    .io_Command              (cmd),
    .io_CommandArgument      (arg),
    .io____state             (state)
  );

  always #5 clock = ~clock;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Remainder of msg(x) * x^7 divided by x^7 + x^3 + 1
  function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'b0};
    for (int i = 46; i >= 7; i--) if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] make_frame(input logic [5:0] c, input logic [31:0] a);
    return {2'b01, c, a, crc7_ref({2'b01, c, a}), 1'b1};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: receiver behaviour expressed on the serial window
  int          m_phase;
  longint      m_n;
  logic        m_cd, m_ad, m_ok;
  logic [5:0]  m_cmd;
  logic [31:0] m_arg;

  task automatic model_reset();
    m_phase = 0; m_n = 0; m_cd = 0; m_ad = 0; m_ok = 0; m_cmd = 0; m_arg = 0;
  endtask

  task automatic model_step();
    logic ok;
    case (m_phase)
      0: if (tb_buf[7:6] == 2'b01) begin
           m_cmd = tb_buf[5:0]; m_cd = 1; m_ad = 0; m_ok = 0; m_n = 0; m_phase = 1;
         end
      1: begin
           m_n++;
           if (m_n % 8 == 0) m_arg = {m_arg[23:0], tb_buf};
           if (m_n == 32) begin m_ad = 1; m_n = 0; m_phase = 2; end
         end
      2: begin
           m_n++;
           if (m_n == 8) begin
             ok = tb_buf[0];
`ifdef SPI_CRC7_CHECK_EN
             ok = ok && (tb_buf[7:1] == crc7_ref({2'b01, m_cmd, m_arg}));
`endif
             m_ok = ok;
             m_n = 0;
             m_phase = (ok && m_cmd == 6'd24) ? 3 : 0;
           end
         end
      3: if (tb_buf == 8'hFE) begin m_n = 0; m_phase = (size == 0) ? 5 : 4; end
      4: begin
           m_n++;
           if (m_n == longint'(size) * 8) begin m_n = 0; m_phase = 5; end
         end
      default: begin
           m_n++;
           if (m_n == 16) begin m_n = 0; m_phase = 0; end
         end
    endcase
  endtask

  task automatic compare_model();
    check("model cmd_done", 32'(cmd_done), 32'(m_cd));
    check("model arg_done", 32'(arg_done), 32'(m_ad));
    check("model success", 32'(success), 32'(m_ok));
    check("model cmd", 32'(cmd), 32'(m_cmd));
    check("model arg", arg, m_arg);
    check("model state", 32'(state), 32'(m_phase));
  endtask

  task automatic send_bit(input logic b);
    @(negedge clock);
    tb_buf = {tb_buf[6:0], b};
    changed = 1'b1;
    repeat ($urandom_range(1, 2)) @(negedge clock);
    changed = 1'b0;
    @(negedge clock);
    model_step();
    compare_model();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_ones(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) send_bit(f[i]);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    changed = 1'b0;
    tb_buf = 8'hFF;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " state"}, 32'(state), 32'd0);
    check({tag, " cmd_done"}, 32'(cmd_done), 32'd0);
    check({tag, " arg_done"}, 32'(arg_done), 32'd0);
    check({tag, " success"}, 32'(success), 32'd0);
    check({tag, " cmd"}, 32'(cmd), 32'd0);
    check({tag, " arg"}, arg, 32'd0);
  endtask

  typedef struct {
    logic [47:0] frame;
    logic        exp_success;
    logic [2:0]  exp_state;
    logic [5:0]  exp_cmd;
    logic [31:0] exp_arg;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0] cb;
    logic [5:0] rc;
    logic [31:0] ra;

    vecs[0] = '{48'h40_0000_0000_95, 1'b1, 3'd0, 6'd0, 32'd0};
    vecs[1] = '{48'h40_0000_0000_94, 1'b0, 3'd0, 6'd0, 32'd0};
`ifdef SPI_CRC7_CHECK_EN
    vecs[2] = '{48'h40_0000_0000_01, 1'b0, 3'd0, 6'd0, 32'd0};
`else
    vecs[2] = '{48'h40_0000_0000_01, 1'b1, 3'd0, 6'd0, 32'd0};
`endif
    vecs[3] = '{make_frame(6'd16, 32'h0000_0800), 1'b1, 3'd0, 6'd16, 32'h0000_0800};
    vecs[4] = '{make_frame(6'd24, 32'h1234_5678), 1'b1, 3'd3, 6'd24, 32'h1234_5678};
    vecs[5] = '{make_frame(6'd24, 32'hCAFE_0001) ^ 48'd1, 1'b0, 3'd0, 6'd24, 32'hCAFE_0001};

    // Reset state
    do_reset();
    check_idle_outputs("reset");

    // Table-driven complete frames
    for (int v = 0; v < 6; v++) begin
      do_reset();
      send_ones(8);
      send_frame(vecs[v].frame);
      check($sformatf("vec%0d cmd_done", v), 32'(cmd_done), 32'd1);
      check($sformatf("vec%0d arg_done", v), 32'(arg_done), 32'd1);
      check($sformatf("vec%0d success", v), 32'(success), 32'(vecs[v].exp_success));
      check($sformatf("vec%0d state", v), 32'(state), 32'(vecs[v].exp_state));
      check($sformatf("vec%0d cmd", v), 32'(cmd), 32'(vecs[v].exp_cmd));
      check($sformatf("vec%0d arg", v), arg, vecs[v].exp_arg);
    end

    // Command then argument capture points
    do_reset();
    send_ones(8);
    send_byte(8'h50);
    check("seq cmd_done after bit 8", 32'(cmd_done), 32'd1);
    check("seq cmd after bit 8", 32'(cmd), 32'd16);
    check("seq arg_done after bit 8", 32'(arg_done), 32'd0);
    check("seq state after bit 8", 32'(state), 32'd1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h08); send_byte(8'h00);
    check("seq arg_done after bit 40", 32'(arg_done), 32'd1);
    check("seq arg after bit 40", arg, 32'h0000_0800);
    check("seq state after bit 40", 32'(state), 32'd2);

    // Write-block data phase, 4 bytes
    do_reset();
    size = 32'd4;
    send_ones(8);
    send_frame(make_frame(6'd24, 32'd0));
    check("wr state wait", 32'(state), 32'd3);
    send_byte(8'hFF);
    send_byte(8'hFE);
    check("wr state data", 32'(state), 32'd4);
    for (int i = 0; i < 31; i++) send_bit(1'($urandom_range(0, 1)));
    check("wr state data last bit", 32'(state), 32'd4);
    send_bit(1'b0);
    check("wr state data crc", 32'(state), 32'd5);
    send_byte(8'hA5);
    check("wr state mid crc", 32'(state), 32'd5);
    send_byte(8'h5A);
    check("wr state done", 32'(state), 32'd0);

    // Zero-length block skips straight to the data CRC
    do_reset();
    size = 32'd0;
    send_ones(8);
    send_frame(make_frame(6'd24, 32'h0000_0200));
    send_byte(8'hFE);
    check("zero size state", 32'(state), 32'd5);
    send_byte(8'hFF); send_byte(8'hFF);
    check("zero size done", 32'(state), 32'd0);

    // Reset during the argument aborts the frame
    do_reset();
    send_ones(8);
    send_byte(8'h40);
    for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)));
    check("abort state before reset", 32'(state), 32'd1);
    do_reset();
    check_idle_outputs("abort");
    send_ones(8);
    send_frame(make_frame(6'd0, 32'd0));
    check("abort next success", 32'(success), 32'd1);
    check("abort next state", 32'(state), 32'd0);

    // Randomised continuous stream against the model
    do_reset();
    for (int f = 0; f < 40; f++) begin
      if (m_phase == 0) size = 32'($urandom_range(0, 3));
      send_ones($urandom_range(1, 10));
      case ($urandom_range(0, 3))
        0: rc = 6'd24;
        1: rc = 6'd0;
        2: rc = 6'd16;
        default: rc = 6'($urandom_range(0, 63));
      endcase
      ra = $urandom;
      cb = {crc7_ref({2'b01, rc, ra}), 1'b1};
      if ($urandom_range(0, 3) == 0) cb = cb ^ (8'd1 << $urandom_range(0, 7));
      send_frame({2'b01, rc, ra, cb});
      if (rc == 6'd24) begin
        send_ones($urandom_range(1, 4));
        send_byte(8'hFE);
        for (int i = 0; i < int'(size) + 2; i++) send_byte(8'($urandom_range(0, 255)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
